// File: rtl/alu_issue_controller.sv
// Issue controller for a vector ALU: buffers instructions in a small FIFO and sequences each one
// through operand read, execute (with completion timeout) and destination write-back.
module alu_issue_controller #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned QUEUE_DEPTH    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_issue_valid,
    output logic                           out_issue_ready,
    input  logic [31:0]                    in_opcode,
    input  logic [NUM_SRC*12-1:0]          in_src_addr,
    input  logic [11:0]                    in_dest1_addr,
    input  logic [11:0]                    in_dest2_addr,
    input  logic                           in_valu_done,
    output logic [NUM_SRC*4-1:0]           out_src_mux_select,
    output logic [NUM_SRC*10-1:0]          out_src_constant,
    output logic [NUM_SRC-1:0]             out_vgpr_src_rd_en,
    output logic                           out_sgpr_rd_en,
    output logic                           out_exec_rd_en,
    output logic                           out_src_buffer_wr_en,
    output logic                           out_alu_start,
    output logic [31:0]                    out_alu_control,
    output logic                           out_vgpr_wr_en,
    output logic                           out_sgpr_wr_en,
    output logic [11:0]                    out_vgpr_dest_addr,
    output logic [11:0]                    out_sgpr_dest_addr,
    output logic                           out_instr_done,
    output logic                           out_timeout,
    output logic                           out_decode_err,
    output logic                           out_busy,
    output logic [$clog2(QUEUE_DEPTH):0]   out_queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned SRC_W = NUM_SRC * 12;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [31:0]      opcode;
        logic [SRC_W-1:0] src;
        logic [11:0]      dest1;
        logic [11:0]      dest2;
    } instr_t;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StEx,
        StWb
    } state_e;

    state_e                  state_q, state_d;
    instr_t                  mem_q [QUEUE_DEPTH];
    instr_t                  cur_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [TMO_W-1:0]        ex_cnt_q, ex_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [NUM_SRC*4-1:0]    mux_sel_q;
    logic [NUM_SRC*10-1:0]   src_const_q;
    logic                    push, pop;
    logic [NUM_SRC*4-1:0]    dec_sel;
    logic [NUM_SRC*10-1:0]   dec_const;
    logic [NUM_SRC-1:0]      dec_vgpr;
    logic                    dec_err;

    // Operand source class; unrecognised encodings map to 15 so the mux never sees X.
    function automatic logic [3:0] decode_src(input logic [11:0] a);
        logic [3:0] sel;
        if (a == 12'h7FF) begin
            sel = 4'd0;
        end else if (a[11:10] == 2'b00) begin
            sel = 4'd1;
        end else if (a[11:10] == 2'b10) begin
            sel = 4'd2;
        end else if (a[11:9] == 3'b110) begin
            sel = 4'd3;
        end else begin
            case (a)
                12'hE01: sel = 4'd4;
                12'hE02: sel = 4'd5;
                12'hE04: sel = 4'd6;
                12'hE08: sel = 4'd7;
                12'hE10: sel = 4'd8;
                12'hE20: sel = 4'd9;
                12'hE40: sel = 4'd10;
                12'hE80: sel = 4'd11;
                default: sel = 4'd15;
            endcase
        end
        return sel;
    endfunction

    assign out_issue_ready = (count_q < CNT_W'(QUEUE_DEPTH));
    assign push            = in_issue_valid && out_issue_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage needs no reset: entries are only read when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{opcode: in_opcode, src: in_src_addr,
                                 dest1: in_dest1_addr, dest2: in_dest2_addr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        timeout_d = 1'b0;
        ex_cnt_d  = ex_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StRd;
                end
            end
            StRd: begin
                ex_cnt_d = '0;
                state_d  = StEx;
            end
            StEx: begin
                ex_cnt_d = ex_cnt_q + TMO_W'(1);
                if (in_valu_done) begin
                    state_d = StWb;
                end else if (ex_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StWb: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StRd;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            ex_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            mux_sel_q   <= '0;
            src_const_q <= '0;
        end else begin
            state_q   <= state_d;
            ex_cnt_q  <= ex_cnt_d;
            timeout_q <= timeout_d;
            if (pop) begin
                cur_q <= mem_q[rd_ptr_q];
            end
            // Captured at the end of RD so they are stable from the first EX cycle onward.
            if (state_q == StRd) begin
                mux_sel_q   <= dec_sel;
                src_const_q <= dec_const;
            end
        end
    end

    always_comb begin
        dec_sel   = '0;
        dec_const = '0;
        dec_vgpr  = '0;
        dec_err   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dec_sel[4*i +: 4]    = decode_src(cur_q.src[12*i +: 12]);
            dec_const[10*i +: 10] = cur_q.src[12*i +: 10];
            dec_vgpr[i]          = (dec_sel[4*i +: 4] == 4'd2);
            if (dec_sel[4*i +: 4] == 4'd15) begin
                dec_err = 1'b1;
            end
        end
    end

    assign out_src_mux_select   = mux_sel_q;
    assign out_src_constant     = src_const_q;
    assign out_src_buffer_wr_en = (state_q == StRd);
    assign out_sgpr_rd_en       = (state_q == StRd);
    assign out_exec_rd_en       = (state_q == StRd);
    assign out_vgpr_src_rd_en   = (state_q == StRd) ? dec_vgpr : '0;
    assign out_decode_err       = (state_q == StRd) && dec_err;
    assign out_alu_start        = (state_q == StEx) && (ex_cnt_q == '0);
    assign out_alu_control      = (state_q == StEx) ? cur_q.opcode : 32'h0;
    assign out_timeout          = timeout_q;
    assign out_busy             = (state_q != StIdle) || (count_q != '0);
    assign out_queue_count      = count_q;

    always_comb begin
        out_instr_done     = 1'b0;
        out_vgpr_wr_en     = 1'b0;
        out_sgpr_wr_en     = 1'b0;
        out_vgpr_dest_addr = 12'h0;
        out_sgpr_dest_addr = 12'h0;
        if (state_q == StWb) begin
            out_instr_done = 1'b1;
            out_vgpr_wr_en = (cur_q.dest1[11:10] == 2'b10) || (cur_q.dest2[11:10] == 2'b10);
            out_sgpr_wr_en = (cur_q.dest1[11:10] == 2'b11) || (cur_q.dest2[11:10] == 2'b11);
            // dest1 class takes priority in deciding which field feeds which register file.
            if (cur_q.dest1[11:10] == 2'b10) begin
                out_vgpr_dest_addr = cur_q.dest1;
                out_sgpr_dest_addr = cur_q.dest2;
            end else if (cur_q.dest1[11:10] == 2'b11) begin
                out_vgpr_dest_addr = cur_q.dest2;
                out_sgpr_dest_addr = cur_q.dest1;
            end else if (cur_q.dest2[11:10] == 2'b10) begin
                out_vgpr_dest_addr = cur_q.dest2;
                out_sgpr_dest_addr = cur_q.dest1;
            end else if (cur_q.dest2[11:10] == 2'b11) begin
                out_vgpr_dest_addr = cur_q.dest1;
                out_sgpr_dest_addr = cur_q.dest2;
            end
        end
    end

endmodule

// File: doc/alu_issue_controller.md
ALU_ISSUE_CONTROLLER -- requirements
Module: alu_issue_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of source operands (1..4).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, issue-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, max EX cycles waiting for in_valu_done (>=1).
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-low (one clock; reset asynchronous active-low).
REQ-005 SHALL have ports: in_issue_valid input 1 issue request; out_issue_ready output 1 queue can accept.
REQ-006 SHALL have ports: in_opcode input 32; in_src_addr input NUM_SRC*12, operand i at [12i+11:12i]; in_dest1_addr input 12; in_dest2_addr input 12.
REQ-007 SHALL have port in_valu_done input 1 execution-unit completion.
REQ-008 SHALL have ports: out_src_mux_select output NUM_SRC*4; out_src_constant output NUM_SRC*10; out_vgpr_src_rd_en output NUM_SRC; out_sgpr_rd_en output 1; out_exec_rd_en output 1; out_src_buffer_wr_en output 1.
REQ-009 SHALL have ports: out_alu_start output 1; out_alu_control output 32; out_vgpr_wr_en output 1; out_sgpr_wr_en output 1; out_vgpr_dest_addr output 12; out_sgpr_dest_addr output 12; out_instr_done output 1.
REQ-010 SHALL have ports: out_timeout output 1 pulse; out_decode_err output 1; out_busy output 1; out_queue_count output $clog2(QUEUE_DEPTH)+1.

Function
REQ-011 SHALL push {opcode, src, dests} into a FIFO on posedge clk when in_issue_valid && out_issue_ready; out_issue_ready = count < QUEUE_DEPTH.
REQ-012 SHALL ignore in_issue_valid while full; simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-013 SHALL run FSM IDLE, RD, EX, WB; IDLE->RD when count>0, popping the head into a current-instruction register on that edge.
REQ-014 RD SHALL last one cycle, then EX; during RD: out_src_buffer_wr_en=1, out_sgpr_rd_en=1, out_exec_rd_en=1, out_vgpr_src_rd_en[i]=1 iff source i decodes as VGPR.
REQ-015 Per-source decode (12-bit addr): 0x7FF literal->0; 0b00xxxxxxxxxx constant->1; 0b10xxxxxxxxxx VGPR->2; 0b110xxxxxxxxx SGPR->3; 0xE01 VCC_LO->4; 0xE02 VCC_HI->5; 0xE04 M0->6; 0xE08 EXEC_LO->7; 0xE10 EXEC_HI->8; 0xE20 VCCZ->9; 0xE40 EXECZ->10; 0xE80 SCC->11; any other->15 (never X).
REQ-016 out_src_mux_select and out_src_constant (addr[9:0]) SHALL be registered, valid in the first EX cycle and held until next RD.
REQ-017 out_decode_err SHALL be 1 during RD when any source decodes to 15; instruction still executes.
REQ-018 out_alu_start SHALL pulse one cycle in the first EX cycle; out_alu_control = opcode while in EX, else 0.
REQ-019 EX->WB on edge where in_valu_done=1; in_valu_done outside EX SHALL be ignored.
REQ-020 EX cycle counter SHALL reset on RD; if TIMEOUT_CYCLES EX cycles elapse without done, EX->IDLE, out_timeout=1 one cycle, no WB, no out_instr_done.
REQ-021 WB SHALL last one cycle: out_instr_done=1; dest routing: dest1[11:10]=10 -> vgpr=dest1, sgpr=dest2; dest1=11 -> vgpr=dest2, sgpr=dest1; else dest2=10 -> vgpr=dest2, sgpr=dest1; dest2=11 -> vgpr=dest1, sgpr=dest2; else both 0.
REQ-022 In WB out_vgpr_wr_en=1 iff a dest field [11:10]=10; out_sgpr_wr_en=1 iff a dest field [11:10]=11; both 0 outside WB.
REQ-023 WB->RD (pop) when count>0, else WB->IDLE; back-to-back issue SHALL have no bubble.
REQ-024 out_busy = (state != IDLE) || count>0.
REQ-025 Latency: push at edge E0 into empty idle block -> RD after E1, EX after E2, done sampled at E3 -> out_instr_done high cycle after E3.

Reset
REQ-026 rst low SHALL asynchronously force IDLE, count 0, pointers 0, counters 0, current-instruction register 0, and every output 0 except out_issue_ready=1.
REQ-027 rst asserted mid-instruction SHALL discard queue and in-flight instruction; no WB after release.

Verification
REQ-028 Single VGPR-src add (src0=0x805, src1=0x003, dest1=0x80A), done first EX cycle -> mux 2/1, vgpr_rd_en=01, instr_done 3 cycles after push, vgpr_dest=0x80A, vgpr_wr_en=1.
REQ-029 Push 3 with QUEUE_DEPTH=2 while EX stalled -> ready low after 2nd push, 3rd held; WB->RD back-to-back, 3 instr_done pulses, in order.
REQ-030 No done for 64 EX cycles -> out_timeout single pulse, no instr_done, FSM IDLE, next queued instr proceeds.
REQ-031 src addr 0xE03 -> mux select 15, out_decode_err=1 during RD.
REQ-032 dest1=0xC6A, dest2=0x812 -> sgpr_dest=0xC6A, vgpr_dest=0x812, both wr_en=1 in WB.
REQ-033 rst low during EX with 1 queued -> outputs 0, ready=1, count 0 immediately; no WB after release.
